// File: rtl/pe_request_arbiter_pkg.sv
// Shared peripheral-interconnect helpers: pointer width and ID width relation.
package pe_request_arbiter_pkg;

    // Width of an index into n entries; never below one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The one-hot transaction ID carries one bit per master.
    function automatic bit id_width_ok(input int n_master, input int id_width);
        return (id_width == n_master);
    endfunction

endpackage

// File: rtl/pe_request_arbiter_if.sv
// Request bus between N masters, the arbiter and a single peripheral port.
// slave  : arbiter view (takes master requests, drives grants and the peripheral side)
// master : environment view (masters plus the peripheral model)
interface pe_request_arbiter_if #(
    parameter int N_MASTER   = 4,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [N_MASTER-1:0]            data_req_i;
    logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0]            data_wen_i;
    logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i;
    logic [N_MASTER*BE_WIDTH-1:0]   data_be_i;
    logic [N_MASTER-1:0]            data_gnt_o;
    logic                           data_req_o;
    logic [ADDR_WIDTH-1:0]          data_add_o;
    logic                           data_wen_o;
    logic [DATA_WIDTH-1:0]          data_wdata_o;
    logic [BE_WIDTH-1:0]            data_be_o;
    logic [ID_WIDTH-1:0]            data_ID_o;
    logic                           data_gnt_i;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_gnt_i,
        output data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
               data_ID_o
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_gnt_i,
        input  data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
               data_ID_o
    );
endinterface

// File: rtl/pe_request_arbiter_rr_priority_sel.sv
// Round-robin priority select: first set request at or after ptr, wrapping.
// The request vector is doubled and the lower copy masked below ptr, so a
// plain lowest-set-bit search yields the rotated winner.
module pe_rr_priority_sel
    import pe_request_arbiter_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int PW       = ptr_width(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [PW-1:0]       ptr,
    output logic [N_MASTER-1:0] win_oh,
    output logic [PW-1:0]       win_idx
);
    logic [2*N_MASTER-1:0] dbl;
    int                    pos;
    logic                  found;

    // Lowest set bit of the masked, doubled request vector.
    always_comb begin
        dbl   = {req, req};
        for (int i = 0; i < N_MASTER; i++)
            if (i < int'(ptr)) dbl[i] = 1'b0;
        pos   = 0;
        found = 1'b0;
        for (int i = 2*N_MASTER-1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos   = i;
                found = 1'b1;
            end
        end
        win_idx = (pos >= N_MASTER) ? PW'(pos - N_MASTER) : PW'(pos);
        win_oh  = '0;
        if (found) win_oh[win_idx] = 1'b1;
    end
endmodule

// File: rtl/pe_request_arbiter.sv
// Round-robin arbiter of N masters onto one peripheral port. The chosen
// master stays locked while the peripheral stalls, and the transaction is
// tagged with a one-hot ID for routing the response back.
module pe_request_arbiter
    import pe_request_arbiter_pkg::*;
#(
    parameter int N_MASTER   = 4,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input logic                  clk,
    input logic                  rst_n,
    pe_request_arbiter_if.slave  bus
);
    localparam int PW = ptr_width(N_MASTER);

    if (!id_width_ok(N_MASTER, ID_WIDTH)) begin : g_bad_id_width
        $error("pe_request_arbiter: ID_WIDTH must equal N_MASTER");
    end
    if (N_MASTER < 2) begin : g_bad_n_master
        $error("pe_request_arbiter: N_MASTER must be at least 2");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       lock_idx;
    logic [N_MASTER-1:0] rr_oh;
    logic [PW-1:0]       rr_idx;
    logic [N_MASTER-1:0] lock_oh;
    logic [PW-1:0]       sel_idx;
    logic                req_sel;
    logic                hs;

    pe_rr_priority_sel #(.N_MASTER(N_MASTER), .PW(PW)) u_sel (
        .req     (bus.data_req_i),
        .ptr     (rr_ptr),
        .win_oh  (rr_oh),
        .win_idx (rr_idx)
    );

    // Winner: rotating priority in IDLE, the locked master in HOLD.
    always_comb begin
        lock_oh           = '0;
        lock_oh[lock_idx] = 1'b1;
        if (state == HOLD) begin
            sel_idx = lock_idx;
            req_sel = bus.data_req_i[lock_idx];
        end else begin
            sel_idx = rr_idx;
            req_sel = |bus.data_req_i;
        end
    end

    assign hs = req_sel & bus.data_gnt_i;

    // Zero-latency request path; idle bus reads as a non-write with no ID.
    always_comb begin
        bus.data_req_o   = req_sel;
        bus.data_add_o   = '0;
        bus.data_wen_o   = 1'b1;
        bus.data_wdata_o = '0;
        bus.data_be_o    = '0;
        bus.data_ID_o    = '0;
        if (req_sel) begin
            bus.data_add_o   = bus.data_add_i[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.data_wen_o   = bus.data_wen_i[sel_idx];
            bus.data_wdata_o = bus.data_wdata_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
            bus.data_be_o    = bus.data_be_i[int'(sel_idx)*BE_WIDTH +: BE_WIDTH];
            bus.data_ID_o    = ID_WIDTH'((state == HOLD) ? lock_oh : rr_oh);
        end
    end

    assign bus.data_gnt_o = N_MASTER'(bus.data_ID_o) & {N_MASTER{bus.data_gnt_i}};

    // Arbitration FSM: lock on stall, advance priority only on a handshake.
    // A locked master that withdraws just releases the lock, pointer untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else if (hs) begin
            state  <= IDLE;
            rr_ptr <= (sel_idx == PW'(N_MASTER-1)) ? '0 : sel_idx + 1'b1;
        end else if (state == IDLE && req_sel) begin
            state    <= HOLD;
            lock_idx <= sel_idx;
        end else if (state == HOLD && !req_sel) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_pe_request_arbiter.sv
// Directed checks of the round-robin request arbiter.
module tb_pe_request_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pe_request_arbiter_if #(.N_MASTER(N), .ID_WIDTH(N), .ADDR_WIDTH(AW),
                            .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    pe_request_arbiter #(.N_MASTER(N), .ID_WIDTH(N), .ADDR_WIDTH(AW),
                         .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h100;
    endfunction
    function automatic logic [DW-1:0] wdata_of(input int k);
        return 32'hD0D0_0000 + 32'(k);
    endfunction
    function automatic logic [BW-1:0] be_of(input int k);
        return 4'b0001 << k;
    endfunction

    task automatic set_idle();
        bus.data_req_i = '0;
        bus.data_gnt_i = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        bus.data_gnt_i = 1'b1;
        #2;
        checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.data_req_o); end
        checks++; if (bus.data_wen_o !== 1'b1) begin errors++; $display("FAIL reset_wen got %b want 1", bus.data_wen_o); end
        checks++; if (bus.data_ID_o !== 4'b0000) begin errors++; $display("FAIL reset_id got %b want 0000", bus.data_ID_o); end
        checks++; if (bus.data_gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.data_gnt_o); end
        checks++; if (bus.data_add_o !== 32'h0) begin errors++; $display("FAIL reset_add got %h want 0", bus.data_add_o); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr); end
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.data_req_i = 4'b0100;
        bus.data_gnt_i = 1'b1;
        #2;
        checks++; if (bus.data_req_o !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", bus.data_req_o); end
        checks++; if (bus.data_ID_o !== 4'b0100) begin errors++; $display("FAIL single_id got %b want 0100", bus.data_ID_o); end
        checks++; if (bus.data_gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", bus.data_gnt_o); end
        checks++; if (bus.data_add_o !== addr_of(2)) begin errors++; $display("FAIL single_add got %h want %h", bus.data_add_o, addr_of(2)); end
        checks++; if (bus.data_wdata_o !== wdata_of(2)) begin errors++; $display("FAIL single_wdata got %h want %h", bus.data_wdata_o, wdata_of(2)); end
        checks++; if (bus.data_be_o !== be_of(2)) begin errors++; $display("FAIL single_be got %b want %b", bus.data_be_o, be_of(2)); end
        checks++; if (bus.data_wen_o !== 1'b0) begin errors++; $display("FAIL single_wen got %b want 0", bus.data_wen_o); end
        @(negedge clk);
        set_idle();
        #2;
        checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus.data_req_i = 4'b1001;
        bus.data_gnt_i = 1'b1;
        #2;
        checks++; if (bus.data_ID_o !== 4'b1000) begin errors++; $display("FAIL wrap_id3 got %b want 1000", bus.data_ID_o); end
        checks++; if (bus.data_add_o !== addr_of(3)) begin errors++; $display("FAIL wrap_add3 got %h want %h", bus.data_add_o, addr_of(3)); end
        checks++; if (bus.data_wen_o !== 1'b1) begin errors++; $display("FAIL wrap_wen3 got %b want 1", bus.data_wen_o); end
        @(negedge clk);
        bus.data_req_i = 4'b0001;
        #2;
        checks++; if (bus.data_ID_o !== 4'b0001) begin errors++; $display("FAIL wrap_id0 got %b want 0001", bus.data_ID_o); end
        checks++; if (bus.data_gnt_o !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b want 0001", bus.data_gnt_o); end
        @(negedge clk);
        set_idle();
        #2;
        checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL wrap_ptr got %0d want 1", dut.rr_ptr); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_id;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.data_req_i = 4'b1111;
            bus.data_gnt_i = 1'b1;
            #2;
            exp_id = 4'b0001 << (i % 4);
            checks++; if (bus.data_ID_o !== exp_id) begin errors++; $display("FAIL rot_id[%0d] got %b want %b", i, bus.data_ID_o, exp_id); end
            checks++; if (bus.data_gnt_o !== exp_id) begin errors++; $display("FAIL rot_gnt[%0d] got %b want %b", i, bus.data_gnt_o, exp_id); end
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_hold();
        do_reset();
        bus.data_req_i = 4'b0010;
        bus.data_gnt_i = 1'b0;
        #2;
        checks++; if (bus.data_ID_o !== 4'b0010) begin errors++; $display("FAIL hold_id_c1 got %b want 0010", bus.data_ID_o); end
        checks++; if (bus.data_gnt_o !== 4'b0000) begin errors++; $display("FAIL hold_gnt_c1 got %b want 0000", bus.data_gnt_o); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            bus.data_req_i = 4'b0011;
            #2;
            checks++; if (bus.data_ID_o !== 4'b0010) begin errors++; $display("FAIL hold_id_c%0d got %b want 0010", c, bus.data_ID_o); end
            checks++; if (bus.data_add_o !== addr_of(1)) begin errors++; $display("FAIL hold_add_c%0d got %h want %h", c, bus.data_add_o, addr_of(1)); end
        end
        @(negedge clk);
        bus.data_gnt_i = 1'b1;
        #2;
        checks++; if (bus.data_gnt_o !== 4'b0010) begin errors++; $display("FAIL hold_gnt_c4 got %b want 0010", bus.data_gnt_o); end
        @(negedge clk);
        bus.data_req_i = 4'b0001;
        #2;
        checks++; if (bus.data_ID_o !== 4'b0001) begin errors++; $display("FAIL hold_id_c5 got %b want 0001", bus.data_ID_o); end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_drop();
        do_reset();
        bus.data_req_i = 4'b0100;
        bus.data_gnt_i = 1'b0;
        #2;
        checks++; if (bus.data_ID_o !== 4'b0100) begin errors++; $display("FAIL drop_lock_id got %b want 0100", bus.data_ID_o); end
        @(negedge clk);
        bus.data_req_i = 4'b0001;
        #2;
        checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL drop_req got %b want 0", bus.data_req_o); end
        checks++; if (bus.data_gnt_o !== 4'b0000) begin errors++; $display("FAIL drop_gnt got %b want 0000", bus.data_gnt_o); end
        checks++; if (bus.data_ID_o !== 4'b0000) begin errors++; $display("FAIL drop_id got %b want 0000", bus.data_ID_o); end
        @(negedge clk);
        #2;
        checks++; if (bus.data_ID_o !== 4'b0001) begin errors++; $display("FAIL drop_idle_id got %b want 0001", bus.data_ID_o); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL drop_ptr got %0d want 0", dut.rr_ptr); end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.data_req_i = 4'b0100;
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        bus.data_req_i = 4'b1010;
        bus.data_gnt_i = 1'b0;
        #2;
        checks++; if (bus.data_ID_o !== 4'b1000) begin errors++; $display("FAIL arst_pre_id got %b want 1000", bus.data_ID_o); end
        @(negedge clk);
        #2;
        checks++; if (bus.data_ID_o !== 4'b1000) begin errors++; $display("FAIL arst_hold_id got %b want 1000", bus.data_ID_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL arst_ptr got %0d want 0", dut.rr_ptr); end
        checks++; if (bus.data_ID_o !== 4'b0010) begin errors++; $display("FAIL arst_id got %b want 0010", bus.data_ID_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.data_gnt_i = 1'b1;
        #2;
        checks++; if (bus.data_gnt_o !== 4'b0010) begin errors++; $display("FAIL arst_gnt got %b want 0010", bus.data_gnt_o); end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.data_req_i   = '0;
        bus.data_gnt_i   = 1'b0;
        bus.data_add_i   = '0;
        bus.data_wen_i   = '0;
        bus.data_wdata_i = '0;
        bus.data_be_i    = '0;
        for (int k = 0; k < N; k++) begin
            bus.data_add_i[k*AW +: AW]   = addr_of(k);
            bus.data_wdata_i[k*DW +: DW] = wdata_of(k);
            bus.data_be_i[k*BW +: BW]    = be_of(k);
            bus.data_wen_i[k]            = k[0];
        end
        test_reset();
        test_single();
        test_wrap();
        test_rotation();
        test_hold();
        test_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
